// File: rtl/mips_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_core_pkg
//  Description : Shared MIPS core types: branch outcome, ALU control codes,
//                branch history counter states and branch classification.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [4:0] {
        ALUCTL_NOP   = 5'd0,
        ALUCTL_ADD   = 5'd1,
        ALUCTL_ADDU  = 5'd2,
        ALUCTL_SUB   = 5'd3,
        ALUCTL_SUBU  = 5'd4,
        ALUCTL_AND   = 5'd5,
        ALUCTL_OR    = 5'd6,
        ALUCTL_XOR   = 5'd7,
        ALUCTL_NOR   = 5'd8,
        ALUCTL_SLT   = 5'd9,
        ALUCTL_SLTU  = 5'd10,
        ALUCTL_SLL   = 5'd11,
        ALUCTL_SRL   = 5'd12,
        ALUCTL_SRA   = 5'd13,
        ALUCTL_LUI   = 5'd14,
        ALUCTL_MTCP0 = 5'd15,
        ALUCTL_MFCP0 = 5'd16,
        ALUCTL_BA    = 5'd17,
        ALUCTL_BEQ   = 5'd18,
        ALUCTL_BNE   = 5'd19,
        ALUCTL_BLEZ  = 5'd20,
        ALUCTL_BGTZ  = 5'd21,
        ALUCTL_BGEZ  = 5'd22,
        ALUCTL_BLTZ  = 5'd23
    } AluCtl;

    // 2-bit saturating branch history counter; MSB set means predict taken
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } BhtState;

    localparam BhtState c_BHT_INIT = WEAK_NT;

    // Only conditional branches train the predictor; BA is unconditional
    function automatic logic is_cond_branch(input AluCtl ctl);
        case (ctl)
            ALUCTL_BEQ, ALUCTL_BNE, ALUCTL_BLEZ,
            ALUCTL_BGTZ, ALUCTL_BGEZ, ALUCTL_BLTZ: is_cond_branch = 1'b1;
            default:                               is_cond_branch = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bht_counter
//  Description : Next-state logic of a 2-bit saturating branch counter.
//                TAKEN counts up, NOT_TAKEN counts down, no wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module bht_counter
    import mips_core_pkg::*;
(
    input  BhtState      i_state,
    input  BranchOutcome i_outcome,
    output BhtState      o_next_state
);

    // Step toward the resolved direction, holding at either extreme
    always_comb begin
        o_next_state = i_state;
        if (i_outcome == TAKEN) begin
            if (i_state != STRONG_T) begin
                o_next_state = BhtState'(i_state + 2'd1);
            end
        end else begin
            if (i_state != STRONG_NT) begin
                o_next_state = BhtState'(i_state - 2'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-stage conditional branch direction predictor. Table of
//                2-bit saturating counters indexed by PC, trained by execute,
//                with saturating branch / mispredict statistics.
//                Build option: define BRANCH_PREDICTOR_GSHARE_EN to XOR the
//                index with a global history register (gshare); otherwise a
//                plain bimodal PC-indexed table.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [31:0]           i_req_pc,
    output logic                  o_prediction,
    output logic [INDEX_BITS-1:0] o_pred_ghr,
    input  logic                  i_update_valid,
    input  logic [31:0]           i_update_pc,
    input  logic [4:0]            i_update_alu_ctl,
    input  logic                  i_update_outcome,
    input  logic                  i_update_prediction,
    input  logic [INDEX_BITS-1:0] i_update_ghr,
    output logic [STAT_WIDTH-1:0] o_branch_count,
    output logic [STAT_WIDTH-1:0] o_mispredict_count
);

    localparam int c_ENTRIES = 1 << INDEX_BITS;

    BhtState               r_table [c_ENTRIES];
    logic [STAT_WIDTH-1:0] r_branch_count;
    logic [STAT_WIDTH-1:0] r_mispredict_count;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic                  w_update_en;
    BhtState               w_req_state;
    BhtState               w_next_state;
    logic                  w_unused_bits;

    assign w_update_en = i_update_valid && is_cond_branch(AluCtl'(i_update_alu_ctl));

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;

    // Shift each resolved conditional outcome into the global history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_update_en) begin
            r_ghr <= {r_ghr[INDEX_BITS-2:0], i_update_outcome};
        end
    end

    // Update uses the history carried with the instruction, not the live GHR
    assign w_req_idx  = i_req_pc[INDEX_BITS+1:2] ^ r_ghr;
    assign w_upd_idx  = i_update_pc[INDEX_BITS+1:2] ^ i_update_ghr;
    assign o_pred_ghr = r_ghr;

    assign w_unused_bits = ^{i_req_valid, i_req_pc[31:INDEX_BITS+2], i_req_pc[1:0],
                             i_update_pc[31:INDEX_BITS+2], i_update_pc[1:0]};
`else
    assign w_req_idx  = i_req_pc[INDEX_BITS+1:2];
    assign w_upd_idx  = i_update_pc[INDEX_BITS+1:2];
    assign o_pred_ghr = '0;

    assign w_unused_bits = ^{i_req_valid, i_req_pc[31:INDEX_BITS+2], i_req_pc[1:0],
                             i_update_pc[31:INDEX_BITS+2], i_update_pc[1:0], i_update_ghr};
`endif

    // Lookup reads the table as it stands before this cycle's edge (no bypass)
    assign w_req_state  = r_table[w_req_idx];
    assign o_prediction = (w_req_state == WEAK_T) || (w_req_state == STRONG_T);

    bht_counter u_bht_counter (
        .i_state      (r_table[w_upd_idx]),
        .i_outcome    (BranchOutcome'(i_update_outcome)),
        .o_next_state (w_next_state)
    );

    // Counter table: all entries weakly not-taken out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table[i] <= c_BHT_INIT;
            end
        end else if (w_update_en) begin
            r_table[w_upd_idx] <= w_next_state;
        end
    end

    // Saturating statistics: resolved branches and mispredictions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_update_en) begin
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if ((i_update_prediction != i_update_outcome) && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor. A reference model
//                of the counter table, history and statistics produces the
//                expected {prediction, ghr, branch_count, mispredict_count}
//                vectors, queued in a scoreboard and compared against the DUT.
//                Honors BRANCH_PREDICTOR_GSHARE_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    import mips_core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        prediction;
    logic [5:0]  pred_ghr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [4:0]  update_alu_ctl;
    logic        update_outcome;
    logic        update_prediction;
    logic [5:0]  update_ghr;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0]  m_tbl [64];
    logic [5:0]  m_ghr;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    // Scoreboard
    logic [70:0] sb_q [$];
    string       tag_q [$];
    logic [70:0] obs;
    logic [70:0] exp_v;
    string       tag;

    branch_predictor dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req_valid         (req_valid),
        .i_req_pc            (req_pc),
        .o_prediction        (prediction),
        .o_pred_ghr          (pred_ghr),
        .i_update_valid      (update_valid),
        .i_update_pc         (update_pc),
        .i_update_alu_ctl    (update_alu_ctl),
        .i_update_outcome    (update_outcome),
        .i_update_prediction (update_prediction),
        .i_update_ghr        (update_ghr),
        .o_branch_count      (branch_count),
        .o_mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] m_idx(input logic [31:0] pc, input logic [5:0] h);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        return pc[7:2] ^ h;
`else
        return pc[7:2];
`endif
    endfunction

    function automatic logic m_cond(input logic [4:0] ctl);
        return (ctl == 5'd18) || (ctl == 5'd19) || (ctl == 5'd20) ||
               (ctl == 5'd21) || (ctl == 5'd22) || (ctl == 5'd23);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
        m_ghr = '0;
        m_bc  = '0;
        m_mc  = '0;
    endtask

    task automatic m_update(input logic v, input logic [31:0] pc, input logic [4:0] ctl,
                            input logic outc, input logic pred, input logic [5:0] h);
        logic [5:0] ix;
        if (v && m_cond(ctl)) begin
            ix = m_idx(pc, h);
            if (outc && m_tbl[ix] != 2'b11) m_tbl[ix] = m_tbl[ix] + 2'd1;
            if (!outc && m_tbl[ix] != 2'b00) m_tbl[ix] = m_tbl[ix] - 2'd1;
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (pred != outc && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            m_ghr = {m_ghr[4:0], outc};
`endif
        end
    endtask

    function automatic logic [70:0] m_expect(input logic [31:0] pc);
        logic [5:0] g;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        g = m_ghr;
`else
        g = 6'h00;
`endif
        return {m_tbl[m_idx(pc, m_ghr)][1], g, m_bc, m_mc};
    endfunction

    task automatic sb_push(input string t, input logic [70:0] e);
        sb_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Drive one update for one cycle (inputs applied after the active edge)
    task automatic do_update(input logic [31:0] pc, input logic [4:0] ctl,
                             input logic outc, input logic pred);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_alu_ctl    = ctl;
        update_outcome    = outc;
        update_prediction = pred;
        update_ghr        = m_ghr;
        @(posedge clk);
        m_update(1'b1, pc, ctl, outc, pred, update_ghr);
        #1;
        update_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_alu_ctl = '0;
        update_outcome = 1'b0; update_prediction = 1'b0; update_ghr = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 1'b1;
        req_pc = 32'h0040_0000;
        sb_push("reset_lookup", 71'h0);
        #1;
        obs = {prediction, pred_ghr, branch_count, mispredict_count};
        exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
        for (int i = 0; i < 4; i++) begin
            req_pc = $urandom;
            sb_push("reset_any_pc", 71'h0);
            #1;
            obs = {prediction, pred_ghr, branch_count, mispredict_count};
            exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
        end
    endtask

    task automatic test_train_taken();
        for (int n = 0; n < 3; n++) begin
            do_update(32'h0040_0010, ALUCTL_BEQ, 1'b1, 1'b0);
            req_pc = 32'h0040_0010;
            sb_push("train_taken", m_expect(req_pc));
`ifndef BRANCH_PREDICTOR_GSHARE_EN
            sb_push("train_taken_const", {1'b1, 6'h0, 32'(n + 1), 32'(n + 1)});
`endif
            #1;
            obs = {prediction, pred_ghr, branch_count, mispredict_count};
            while (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", tag, n, obs, exp_v); end
            end
        end
    endtask

    task automatic test_train_not_taken();
        // Four NOT_TAKEN steps from the top, then one TAKEN: checks both
        // the down-walk and that the bottom does not wrap
        for (int n = 0; n < 5; n++) begin
            do_update(32'h0040_0010, ALUCTL_BNE, (n == 4), 1'b1);
            req_pc = 32'h0040_0010;
            sb_push("train_not_taken", m_expect(req_pc));
            #1;
            obs = {prediction, pred_ghr, branch_count, mispredict_count};
            exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", tag, n, obs, exp_v); end
        end
    endtask

    task automatic test_non_branch();
        logic [31:0] bc0, mc0;
        bc0 = m_bc; mc0 = m_mc;
        do_update(32'h0040_0020, ALUCTL_BA, 1'b1, 1'b0);
        do_update(32'h0040_0020, ALUCTL_ADD, 1'b1, 1'b0);
        update_valid = 1'b0; update_alu_ctl = ALUCTL_BEQ; update_outcome = 1'b1;
        @(posedge clk); #1;
        req_pc = 32'h0040_0020;
        sb_push("non_branch", m_expect(req_pc));
        sb_push("non_branch_counts", {1'b0, m_ghr_out(), bc0, mc0});
        #1;
        obs = {prediction, pred_ghr, branch_count, mispredict_count};
        while (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
        end
    endtask

    function automatic logic [5:0] m_ghr_out();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        return m_ghr;
`else
        return 6'h00;
`endif
    endfunction

    task automatic test_same_cycle();
        req_pc            = 32'h0040_0030;
        update_valid      = 1'b1;
        update_pc         = 32'h0040_0030;
        update_alu_ctl    = ALUCTL_BLEZ;
        update_outcome    = 1'b1;
        update_prediction = 1'b0;
        update_ghr        = m_ghr;
        sb_push("same_cycle_pre", m_expect(req_pc));
        #1;
        obs = {prediction, pred_ghr, branch_count, mispredict_count};
        exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
        @(posedge clk);
        m_update(1'b1, update_pc, update_alu_ctl, 1'b1, 1'b0, update_ghr);
        #1 update_valid = 1'b0;
        sb_push("same_cycle_post", m_expect(req_pc));
        #1;
        obs = {prediction, pred_ghr, branch_count, mispredict_count};
        exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
    endtask

    task automatic test_alias();
        rst_n = 1'b0; m_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        do_update(32'h0040_0000, ALUCTL_BGTZ, 1'b1, 1'b0);
        req_pc = 32'h0040_0100;
        sb_push("alias_other", m_expect(req_pc));
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        sb_push("alias_gshare_const", {1'b0, 6'h01, 32'd1, 32'd1});
`else
        sb_push("alias_bimodal_const", {1'b1, 6'h00, 32'd1, 32'd1});
`endif
        #1;
        obs = {prediction, pred_ghr, branch_count, mispredict_count};
        while (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ctl;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 8))
                0: ctl = ALUCTL_BEQ;  1: ctl = ALUCTL_BNE;  2: ctl = ALUCTL_BLEZ;
                3: ctl = ALUCTL_BGTZ; 4: ctl = ALUCTL_BGEZ; 5: ctl = ALUCTL_BLTZ;
                6: ctl = ALUCTL_BA;   7: ctl = ALUCTL_SUB;  default: ctl = ALUCTL_BEQ;
            endcase
            update_valid      = 1'b1;
            update_pc         = {24'h004000, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
            update_alu_ctl    = ctl;
            update_outcome    = 1'($urandom);
            update_prediction = 1'($urandom);
            update_ghr        = m_ghr;
            req_pc            = {24'h004000, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
            sb_push("back_to_back", m_expect(req_pc));
            #1;
            obs = {prediction, pred_ghr, branch_count, mispredict_count};
            exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", tag, n, obs, exp_v); end
            @(posedge clk);
            m_update(1'b1, update_pc, update_alu_ctl, update_outcome, update_prediction, update_ghr);
            #1;
        end
        update_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Train an entry up so the reset has something to clear
        do_update(32'h0040_0050, ALUCTL_BGEZ, 1'b1, 1'b0);
        do_update(32'h0040_0050, ALUCTL_BGEZ, 1'b1, 1'b0);
        update_valid = 1'b1; update_pc = 32'h0040_0050; update_alu_ctl = ALUCTL_BLTZ;
        update_outcome = 1'b1; update_prediction = 1'b0; update_ghr = m_ghr;
        #2 rst_n = 1'b0;
        m_reset();
        req_pc = 32'h0040_0050;
        sb_push("reset_async", 71'h0);
        #1;
        obs = {prediction, pred_ghr, branch_count, mispredict_count};
        exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL %s: got %h expected %h", tag, obs, exp_v); end
        @(posedge clk); #1;
        update_valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            req_pc = 32'h0040_0000 + 32'(i * 4);
            sb_push("reset_mid_entry", 71'h0);
            #1;
            obs = {prediction, pred_ghr, branch_count, mispredict_count};
            exp_v = sb_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", tag, i, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_train_not_taken();
        test_non_branch();
        test_same_cycle();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direction predictor for conditional branches in the fetch stage.
- Indexed by fetch PC; produces a BranchOutcome (TAKEN/NOT_TAKEN) for the fetch/PC-select logic in the same cycle.
- Trained by the execute stage once the ALU resolves a branch (AluCtl branch codes).
- Keeps a table of 2-bit saturating counters plus branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries).
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  1  fetch requests a prediction this cycle
- i_req_pc  input  32  fetch PC
- o_prediction  output  1  BranchOutcome for i_req_pc (combinational)
- o_pred_ghr  output  INDEX_BITS  history snapshot used for this prediction; fetch carries it down the pipe
- i_update_valid  input  1  execute has resolved a control instruction this cycle
- i_update_pc  input  32  PC of the resolved instruction
- i_update_alu_ctl  input  5  AluCtl of the resolved instruction
- i_update_outcome  input  1  actual BranchOutcome
- i_update_prediction  input  1  BranchOutcome predicted at fetch
- i_update_ghr  input  INDEX_BITS  o_pred_ghr value carried with the instruction
- o_branch_count  output  STAT_WIDTH  conditional branches resolved
- o_mispredict_count  output  STAT_WIDTH  conditional branches mispredicted

Behaviour:
- Reset (clock and reset port naming as elsewhere in mips_core; reset is asynchronous and active-low):
  - every table entry = WEAK_NT (2'b01)
  - GHR = 0
  - o_branch_count = 0, o_mispredict_count = 0
  - o_prediction therefore = NOT_TAKEN and o_pred_ghr = 0 immediately after reset.
- Index: idx = pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored.
- Lookup: o_prediction = TAKEN iff table[idx(i_req_pc)] is WEAK_T or STRONG_T.
  - Purely combinational, 0-cycle latency.
  - When i_req_valid = 0 the output is still driven; no state changes.
- Counter states: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - TAKEN increments, NOT_TAKEN decrements.
  - Saturates at 11 and 00; never wraps.
- Conditional branch = i_update_alu_ctl in {ALUCTL_BEQ, ALUCTL_BNE, ALUCTL_BLEZ, ALUCTL_BGTZ, ALUCTL_BGEZ, ALUCTL_BLTZ}.
- Update occurs on the rising edge when i_update_valid = 1 and the instruction is a conditional branch. On that edge:
  - table[idx(i_update_pc)] is trained.
  - o_branch_count += 1.
  - o_mispredict_count += 1 if i_update_prediction != i_update_outcome.
- ALUCTL_BA, non-branch AluCtl, or i_update_valid = 0: no table, GHR, or statistics change.
- Statistics counters saturate at all-ones; they do not wrap.
- Same-cycle request and update to the same entry: the lookup returns the pre-update value. Table writes take effect at the edge; there is no bypass.
- Reset asserted mid-operation clears all state asynchronously. An update pending on the same edge is discarded.
- Single update port; at most one update per cycle by construction.

Optional Feature:
- Macro BRANCH_PREDICTOR_GSHARE_EN.
- Defined (gshare):
  - lookup idx = pc[INDEX_BITS+1:2] ^ GHR.
  - update idx = i_update_pc[INDEX_BITS+1:2] ^ i_update_ghr.
  - o_pred_ghr = GHR.
  - On each qualifying update, GHR <= {GHR[INDEX_BITS-2:0], i_update_outcome}.
- Undefined (bimodal):
  - plain PC index for both lookup and update.
  - GHR register absent; o_pred_ghr tied to 0; i_update_ghr ignored.

Decomposition:
- Add to mips_core_pkg:
  - enum BhtState {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} (logic [1:0]).
  - function is_cond_branch(AluCtl) returning 1 for the six conditional codes.
- Reuse the existing BranchOutcome and AluCtl enums from the package.
- One sub-module: bht_counter.
  - Holds the 2-bit saturating next-state logic: inputs BhtState and BranchOutcome, output BhtState.
  - Combinational; instantiated once on the update path.

Test Plan:
- Reset then lookup pc=0x0040_0000 -> o_prediction=NOT_TAKEN, o_pred_ghr=0, both counts=0.
- Three TAKEN updates (BEQ, pc=0x0040_0010, predicted NOT_TAKEN):
  - after 1st: lookup of 0x0040_0010 -> TAKEN (WEAK_T).
  - after 3rd: state STRONG_T.
  - o_branch_count=3, o_mispredict_count=3.
- From STRONG_T, one NOT_TAKEN update -> still TAKEN (WEAK_T); second NOT_TAKEN -> NOT_TAKEN (WEAK_NT).
- Update with ALUCTL_BA, TAKEN, pc=0x0040_0020 -> entry unchanged (NOT_TAKEN), counts unchanged.
- Request and update to pc=0x0040_0030 in the same cycle (entry WEAK_NT, outcome TAKEN) -> that cycle's o_prediction=NOT_TAKEN; next cycle TAKEN.
- Aliasing: pc=0x0040_0000 and 0x0040_0100 share idx 0 with INDEX_BITS=6.
  - TAKEN update on one -> the other predicts TAKEN (bimodal build).
  - Gshare build with GHR=6'h01: the two differ.
- Reset pulsed mid-run while an update is valid -> all counts 0, all entries predict NOT_TAKEN.
